// File: rtl/uart_cmd_arbiter_if.sv
// Requester and UART-engine signal bundle for uart_cmd_arbiter.
// master: arbiter side; slave: requesters plus UART engine side.
interface uart_cmd_arbiter_if #(
  parameter int NREQ       = 4,
  parameter int CMD_WIDTH  = 16,
  parameter int READ_WIDTH = 8
);
  logic [NREQ*CMD_WIDTH-1:0] req_cmd;
  logic [NREQ-1:0]           req_vld;
  logic [NREQ-1:0]           req_rdy;
  logic [NREQ-1:0]           rsp_vld;
  logic [READ_WIDTH-1:0]     rsp_data;
  logic                      rsp_err;
  logic [CMD_WIDTH-1:0]      uart_cmd_in;
  logic                      uart_cmd_vld;
  logic                      uart_cmd_rdy;
  logic                      uart_read_rdy;
  logic [READ_WIDTH-1:0]     uart_read_data;
  logic                      busy;
  logic [2:0]                grant_id;

  modport master (
    input  req_cmd, req_vld,
    input  uart_cmd_rdy, uart_read_rdy, uart_read_data,
    output req_rdy, rsp_vld, rsp_data, rsp_err,
    output uart_cmd_in, uart_cmd_vld, busy, grant_id
  );

  modport slave (
    output req_cmd, req_vld,
    output uart_cmd_rdy, uart_read_rdy, uart_read_data,
    input  req_rdy, rsp_vld, rsp_data, rsp_err,
    input  uart_cmd_in, uart_cmd_vld, busy, grant_id
  );
endinterface

// File: rtl/uart_cmd_arbiter.sv
// Round-robin arbiter sharing one UART command engine among NREQ
// requesters. Ports: clk, rst (sync, active-high), bus (master modport).
module uart_cmd_arbiter #(
  parameter int NREQ       = 4,
  parameter int CMD_WIDTH  = 16,
  parameter int READ_WIDTH = 8,
  parameter int TIMEOUT    = 50000
) (
  input logic clk,
  input logic rst,
  uart_cmd_arbiter_if.master bus
);
  typedef enum logic [2:0] {
    ARB, ISSUE, WAIT_WR, WAIT_RD, RESP
  } state_t;

  state_t st, st_n;
  logic [2:0] rr_ptr, rr_ptr_n;
  logic [2:0] gid, gid_n;
  logic [CMD_WIDTH-1:0] cmd, cmd_n;
  logic [NREQ-1:0] rdy, rdy_n;
  logic [NREQ-1:0] rvld, rvld_n;
  logic [READ_WIDTH-1:0] rdat, rdat_n;
  logic err, err_n;
  logic cvld, cvld_n;
  logic busy_q;
  logic seen, seen_n;
  logic [15:0] cnt, cnt_n;

  // Rotate requests so bit 0 is rr_ptr; the lowest set bit wins.
  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0] rot;
  logic [3:0] sum;
  logic found;
  logic [2:0] g, g_nxt;
  logic [NREQ-1:0] g_oh, gid_oh;
  logic [CMD_WIDTH-1:0] g_cmd;
  logic expire;

  assign dbl = {bus.req_vld, bus.req_vld} >> rr_ptr;
  assign rot = dbl[NREQ-1:0];
  assign expire = (cnt == 16'(TIMEOUT - 1));

  always_comb begin
    found = 1'b0;
    sum = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        sum = {1'b0, rr_ptr} + 4'(k);
      end
    end
    g = (sum >= 4'(NREQ)) ? 3'(sum - 4'(NREQ)) : sum[2:0];
    g_nxt = ({1'b0, g} + 4'd1 == 4'(NREQ)) ? 3'd0 : g + 3'd1;
  end

  always_comb begin
    g_oh = '0;
    gid_oh = '0;
    g_cmd = '0;
    for (int k = 0; k < NREQ; k++) begin
      g_oh[k] = (3'(k) == g);
      gid_oh[k] = (3'(k) == gid);
      if (3'(k) == g)
        g_cmd = bus.req_cmd[k*CMD_WIDTH +: CMD_WIDTH];
    end
  end

  always_comb begin
    st_n = st;
    rr_ptr_n = rr_ptr;
    gid_n = gid;
    cmd_n = cmd;
    rdy_n = '0;
    rvld_n = '0;
    rdat_n = '0;
    err_n = 1'b0;
    cvld_n = cvld;
    seen_n = seen;
    cnt_n = cnt;
    unique case (st)
      ARB: begin
        cnt_n = '0;
        seen_n = 1'b0;
        if (found) begin
          st_n = ISSUE;
          gid_n = g;
          cmd_n = g_cmd;
          rdy_n = g_oh;
          rr_ptr_n = g_nxt;
          cvld_n = 1'b1;
        end
      end
      ISSUE: begin
        cnt_n = cnt + 16'd1;
        if (cvld && bus.uart_cmd_rdy) begin
          cvld_n = 1'b0;
          cnt_n = '0;
          seen_n = 1'b0;
          st_n = cmd[CMD_WIDTH-1] ? WAIT_WR : WAIT_RD;
        end else if (expire) begin
          cvld_n = 1'b0;
          st_n = RESP;
          rvld_n = gid_oh;
          err_n = 1'b1;
        end
      end
      WAIT_WR: begin
        cnt_n = cnt + 16'd1;
        if (!bus.uart_cmd_rdy) seen_n = 1'b1;
        if (seen && bus.uart_cmd_rdy) begin
          st_n = RESP;
          rvld_n = gid_oh;
        end else if (expire) begin
          st_n = RESP;
          rvld_n = gid_oh;
          err_n = 1'b1;
        end
      end
      WAIT_RD: begin
        cnt_n = cnt + 16'd1;
        if (bus.uart_read_rdy) begin
          st_n = RESP;
          rvld_n = gid_oh;
          rdat_n = bus.uart_read_data;
        end else if (expire) begin
          st_n = RESP;
          rvld_n = gid_oh;
          err_n = 1'b1;
        end
      end
      RESP: st_n = ARB;
      default: st_n = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st <= ARB;
      rr_ptr <= '0;
      gid <= '0;
      cmd <= '0;
      rdy <= '0;
      rvld <= '0;
      rdat <= '0;
      err <= 1'b0;
      cvld <= 1'b0;
      busy_q <= 1'b0;
      seen <= 1'b0;
      cnt <= '0;
    end else begin
      st <= st_n;
      rr_ptr <= rr_ptr_n;
      gid <= gid_n;
      cmd <= cmd_n;
      rdy <= rdy_n;
      rvld <= rvld_n;
      rdat <= rdat_n;
      err <= err_n;
      cvld <= cvld_n;
      busy_q <= (st_n != ARB);
      seen <= seen_n;
      cnt <= cnt_n;
    end
  end

  assign bus.req_rdy = rdy;
  assign bus.rsp_vld = rvld;
  assign bus.rsp_data = rdat;
  assign bus.rsp_err = err;
  assign bus.uart_cmd_in = cmd;
  assign bus.uart_cmd_vld = cvld;
  assign bus.busy = busy_q;
  assign bus.grant_id = gid;
endmodule
